// File: rtl/jtopl_slot_cnt.sv
// jtopl_slot_cnt: OPL operator slot sequencer (18 slots = 3 groups x 6 subslots).
// Define JTOPL_SLOT_CHK_EN to add a redundant one-hot ring that flags counter corruption on err.
module jtopl_slot_cnt #(
  parameter int ZERO_SLOT = 0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cenop,
  output logic [4:0] slot,
  output logic [2:0] subslot,
  output logic [1:0] group,
  output logic       op,
  output logic [3:0] chan,
  output logic       zero,
  output logic       smp,
  output logic       err
);
  logic [4:0] slot_q, slot_d;
  logic [2:0] subslot_q, subslot_d, mod3_d;
  logic [1:0] group_q, group_d;
  logic       op_q, op_d, zero_q, zero_d, smp_q;
  logic [3:0] chan_q, chan_d;
  // Next-state derives from group/subslot only, so every registered output lands with the new slot.
  always_comb begin
    subslot_d = subslot_q >= 3'd5 ? 3'd0 : subslot_q + 3'd1;
    group_d   = subslot_q >= 3'd5 ? (group_q >= 2'd2 ? 2'd0 : group_q + 2'd1) : group_q;
    mod3_d    = subslot_d >= 3'd3 ? subslot_d - 3'd3 : subslot_d;
    slot_d    = 5'(group_d) * 5'd6 + 5'(subslot_d);
    op_d      = subslot_d >= 3'd3;
    chan_d    = 4'(group_d) * 4'd3 + 4'(mod3_d);
    zero_d    = slot_d == 5'(ZERO_SLOT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= 5'd0;
      subslot_q <= 3'd0;
      group_q   <= 2'd0;
      op_q      <= 1'b0;
      chan_q    <= 4'd0;
      zero_q    <= ZERO_SLOT == 0;
      smp_q     <= 1'b0;
    end else begin
      smp_q <= cenop && slot_q == 5'd17;
      if (cenop) begin
        slot_q    <= slot_d;
        subslot_q <= subslot_d;
        group_q   <= group_d;
        op_q      <= op_d;
        chan_q    <= chan_d;
        zero_q    <= zero_d;
      end
    end
  end
`ifdef JTOPL_SLOT_CHK_EN
  logic [17:0] ring_q;
  logic        err_q, err_d;
  always_comb err_d = err_q | (ring_q != (18'd1 << slot_q)) |
                      (slot_q != 5'(group_q) * 5'd6 + 5'(subslot_q));
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= 18'd1;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (cenop) ring_q <= {ring_q[16:0], ring_q[17]};
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign slot    = slot_q;
  assign subslot = subslot_q;
  assign group   = group_q;
  assign op      = op_q;
  assign chan    = chan_q;
  assign zero    = zero_q;
  assign smp     = smp_q;
endmodule

// File: tb/tb_jtopl_slot_cnt.sv
// tb_jtopl_slot_cnt: directed and random checks of the slot sequencer against an arithmetic slot model.
module tb_jtopl_slot_cnt;
  logic       clk = 1'b0, rst = 1'b1, cenop = 1'b0;
  logic [4:0] slot, slot17;
  logic [2:0] subslot, subslot17;
  logic [1:0] group, group17;
  logic [3:0] chan, chan17;
  logic       op, zero, smp, err, op17, zero17, smp17, err17;
  int total = 0, passed = 0;
  int m_slot = 0;
  logic m_smp = 1'b0;
  int smp_at[$];

  always #5 clk = ~clk;

  jtopl_slot_cnt #(.ZERO_SLOT(0)) dut0 (
    .rst(rst), .clk(clk), .cenop(cenop), .slot(slot), .subslot(subslot), .group(group),
    .op(op), .chan(chan), .zero(zero), .smp(smp), .err(err));
  jtopl_slot_cnt #(.ZERO_SLOT(17)) dut1 (
    .rst(rst), .clk(clk), .cenop(cenop), .slot(slot17), .subslot(subslot17), .group(group17),
    .op(op17), .chan(chan17), .zero(zero17), .smp(smp17), .err(err17));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected outputs come straight from the slot number: slot = 6*group + subslot.
  task automatic chk_all();
    chk("slot", int'(slot), m_slot);
    chk("subslot", int'(subslot), m_slot % 6);
    chk("group", int'(group), m_slot / 6);
    chk("op", int'(op), int'(m_slot % 6 >= 3));
    chk("chan", int'(chan), (m_slot / 6) * 3 + (m_slot % 6) % 3);
    chk("zero", int'(zero), int'(m_slot == 0));
    chk("smp", int'(smp), int'(m_smp));
    chk("err", int'(err), 0);
    chk("slot17", int'(slot17), m_slot);
    chk("zero17", int'(zero17), int'(m_slot == 17));
    chk("smp17", int'(smp17), int'(m_smp));
  endtask

  task automatic step(input logic c, input logic r);
    cenop = c;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_slot = 0;
      m_smp = 1'b0;
    end else if (c) begin
      m_smp = m_slot == 17;
      m_slot = (m_slot + 1) % 18;
    end else m_smp = 1'b0;
    cenop = 1'b0;
    rst = 1'b0;
    chk_all();
  endtask

  initial begin
    step(1'b0, 1'b1);
    chk("rst_zero17", int'(zero17), 0);
    chk("rst_zero0", int'(zero), 1);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0);
      if (smp) smp_at.push_back(i);
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b0);
        if (smp) smp_at.push_back(100 + i);
      end
    end
    chk("frame_slot", int'(slot), 0);
    chk("frame_smp_n", smp_at.size(), 1);
    if (smp_at.size() > 0) chk("frame_smp_pos", smp_at[0], 17);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("map_sub", int'(subslot), 4);
    chk("map_grp", int'(group), 1);
    chk("map_op", int'(op), 1);
    chk("map_chan", int'(chan), 4);
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("pre_rst_slot", int'(slot), 9);
    step(1'b1, 1'b1);
    chk("rstc_slot", int'(slot), 0);
    chk("rstc_smp", int'(smp), 0);
    chk("rstc_zero", int'(zero), 1);
    step(1'b1, 1'b0);
    chk("rstc_restart", int'(slot), 1);
    step(1'b0, 1'b1);
    smp_at.delete();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0);
      chk("cont_slot", int'(slot), k % 18);
      if (smp) smp_at.push_back(k);
    end
    chk("cont_smp_n", smp_at.size(), 2);
    if (smp_at.size() == 2) begin
      chk("cont_smp_a", smp_at[0], 18);
      chk("cont_smp_b", smp_at[1], 36);
    end
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b0);
      repeat ($urandom_range(0, 30)) step(1'b0, 1'b0);
    end
`ifdef JTOPL_SLOT_CHK_EN
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    force dut0.group_q = 2'd1;
    @(posedge clk);
    #1;
    release dut0.group_q;
    @(posedge clk);
    #1;
    chk("err_rise", int'(err), 1);
    cenop = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cenop = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", int'(err), 1);
    step(1'b0, 1'b1);
    chk("err_clear", int'(err), 0);
`endif
    step(1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
